// File: rtl/blockade_vram_arbiter.sv
// Blockade VRAM arbiter: shares one single-port synchronous RAM between the
// video fetch path and the 8080 CPU. Video always wins; the CPU is stalled
// through READY until it gets a slot (only in vblank unless CPU_ANYTIME=1).
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ce_vid, vblank, vid_addr   video fetch strobe, blank window, fetch address
//   vid_data                   registered video read data
//   cpu_req, cpu_we, cpu_addr, cpu_wdata   CPU access request (level)
//   cpu_ready                  combinational 8080 READY (low = stall)
//   cpu_ack                    one-clk pulse, the clk after a CPU issue
//   cpu_rdata                  registered CPU read data
//   ram_addr, ram_we, ram_wdata  combinational RAM port (issue cycle only)
//   ram_rdata                  RAM read data, valid one clk after address
module blockade_vram_arbiter #(
    parameter bit CPU_ANYTIME = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_vid,
    input  logic       vblank,
    input  logic [9:0] vid_addr,
    output logic [7:0] vid_data,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [9:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ready,
    output logic       cpu_ack,
    output logic [7:0] cpu_rdata,
    output logic [9:0] ram_addr,
    output logic       ram_we,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata
);

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_VID,
        S_CPU
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            vid_pend;
    logic [AW-1:0]   vid_addr_q;
    logic            cpu_done;
    logic            cpu_we_q;
    logic            vid_issue;
    logic            cpu_issue;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Issue decision and RAM port drive. The port is free whenever no CPU
    // access is completing, so the VID cycle doubles as the slot in which a
    // CPU request that lost to video gets issued.
    always_comb begin
        state_nxt = S_IDLE;
        vid_issue = 1'b0;
        cpu_issue = 1'b0;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (!reset && state != S_CPU) begin
            if (ce_vid || vid_pend) begin
                vid_issue = 1'b1;
                state_nxt = S_VID;
                ram_addr  = vid_pend ? vid_addr_q : vid_addr;
            end else if (cpu_req && !cpu_done && (vblank || CPU_ANYTIME)) begin
                cpu_issue = 1'b1;
                state_nxt = S_CPU;
                ram_addr  = cpu_addr;
                ram_we    = cpu_we;
                ram_wdata = cpu_wdata;
            end
        end
    end

    // Ready stays low until the access has completed for this request
    assign cpu_ready = ~cpu_req | cpu_done;

    // Pending video fetch, CPU handshake flags and read-data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            vid_pend   <= 1'b0;
            vid_addr_q <= '0;
            cpu_done   <= 1'b0;
            cpu_we_q   <= 1'b0;
            cpu_ack    <= 1'b0;
            vid_data   <= '0;
            cpu_rdata  <= '0;
        end else begin
            // A strobe not consumed by this cycle's issue is held for later
            if (ce_vid && !(vid_issue && !vid_pend)) begin
                vid_pend   <= 1'b1;
                vid_addr_q <= vid_addr;
            end else if (vid_issue) begin
                vid_pend   <= 1'b0;
            end

            cpu_ack <= cpu_issue;
            if (cpu_issue) begin
                cpu_we_q <= cpu_we;
            end

            if (state == S_VID) begin
                vid_data <= DW'(ram_rdata);
            end

            // Done blocks re-issue while the CPU keeps the request asserted
            if (state == S_CPU) begin
                if (!cpu_we_q) begin
                    cpu_rdata <= DW'(ram_rdata);
                end
                cpu_done <= 1'b1;
            end else if (!cpu_req) begin
                cpu_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_blockade_vram_arbiter.sv
// Bench for blockade_vram_arbiter: directed vectors, RAM model, and a
// scoreboard monitor that checks video data at its due cycle and CPU
// completions on each cpu_ack.
module tb_blockade_vram_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce_vid;
    logic       vblank;
    logic [9:0] vid_addr;
    logic [7:0] vid_data;
    logic       cpu_req;
    logic       cpu_we;
    logic [9:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_ready;
    logic       cpu_ack;
    logic [7:0] cpu_rdata;
    logic [9:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    blockade_vram_arbiter #(.CPU_ANYTIME(1'b0)) dut (
        .clk       (clk),
        .reset     (reset),
        .ce_vid    (ce_vid),
        .vblank    (vblank),
        .vid_addr  (vid_addr),
        .vid_data  (vid_data),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM model
    logic [7:0] mem [1024];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int cyc = 0;
    int we_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) we_cnt <= we_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int         due;
        logic [7:0] data;
    } vexp_t;

    typedef struct {
        int         due;
        bit         rd;
        logic [7:0] data;
    } cexp_t;

    vexp_t vq[$];
    cexp_t cq[$];
    int    n_ack = 0;
    bit    rd_pend = 1'b0;
    logic [7:0] rd_val;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rd_pend) begin
            chk("cpu_rdata", 32'(cpu_rdata), 32'(rd_val));
            rd_pend = 1'b0;
        end
        if (vq.size() > 0 && vq[0].due <= cyc) begin
            chk("vid_data", 32'(vid_data), 32'(vq[0].data));
            chk("vid_due", 32'(cyc), 32'(vq[0].due));
            void'(vq.pop_front());
        end
        if (cpu_ack) begin
            n_ack++;
            if (cq.size() == 0) begin
                chk("unexpected_ack", 32'(cpu_ack), 32'd0);
            end else begin
                chk("ack_cycle", 32'(cyc), 32'(cq[0].due));
                if (cq[0].rd) begin
                    rd_pend = 1'b1;
                    rd_val  = cq[0].data;
                end
                void'(cq.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cpu_ready) begin
                seen = 1'b1;
                break;
            end
        end
        chk("ready_timeout", 32'(seen), 32'd1);
    endtask

    int k;
    int we0;
    int a0;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h155] = 8'hA5;
        mem[10'h0AA] = 8'h5A;
        mem[10'h040] = 8'h11;
        reset = 1'b1; ce_vid = 1'b0; vblank = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

        // Reset state
        repeat (2) step();
        @(negedge clk);
        chk("rst_vid_data", 32'(vid_data), 32'h00);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h00);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'h0);
        chk("rst_ram_we", 32'(ram_we), 32'h0);
        chk("rst_ram_addr", 32'(ram_addr), 32'h0);
        chk("rst_cpu_ready", 32'(cpu_ready), 32'h1);
        step(); reset = 1'b0;
        step();

        // Unobstructed video fetch
        ce_vid = 1'b1; vid_addr = 10'h155; k = cyc;
        vq.push_back('{k + 2, 8'hA5});
        @(negedge clk);
        chk("t1_ram_addr", 32'(ram_addr), 32'h155);
        chk("t1_ram_we", 32'(ram_we), 32'h0);
        step(); ce_vid = 1'b0; vid_addr = '0;
        @(negedge clk);
        chk("t1_idle_addr", 32'(ram_addr), 32'h0);
        repeat (3) step();

        // CPU write stalled outside vblank, then granted
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h020; cpu_wdata = 8'h3C;
        we0 = we_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_stall_ready", 32'(cpu_ready), 32'h0);
            chk("t2_stall_we", 32'(ram_we), 32'h0);
            step();
        end
        vblank = 1'b1; k = cyc;
        cq.push_back('{k + 1, 1'b0, 8'h00});
        @(negedge clk);
        chk("t2_ram_we", 32'(ram_we), 32'h1);
        chk("t2_ram_addr", 32'(ram_addr), 32'h020);
        wait_ready();
        step(); cpu_req = 1'b0;
        chk("t2_mem", 32'(mem[10'h020]), 32'h3C);
        chk("t2_we_pulses", 32'(we_cnt - we0), 32'd1);
        step();

        // Simultaneous video and CPU read: video first
        ce_vid = 1'b1; vid_addr = 10'h0AA;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h020; k = cyc;
        vq.push_back('{k + 2, 8'h5A});
        cq.push_back('{k + 2, 1'b1, 8'h3C});
        @(negedge clk);
        chk("t3_vid_first", 32'(ram_addr), 32'h0AA);
        chk("t3_vid_we", 32'(ram_we), 32'h0);
        step(); ce_vid = 1'b0; vid_addr = '0;
        @(negedge clk);
        chk("t3_cpu_next", 32'(ram_addr), 32'h020);
        wait_ready();
        step(); cpu_req = 1'b0;
        step();

        // Request held long after ack: single write, single ack
        we0 = we_cnt; a0 = n_ack;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h030; cpu_wdata = 8'h77; k = cyc;
        cq.push_back('{k + 1, 1'b0, 8'h00});
        repeat (12) step();
        cpu_req = 1'b0;
        repeat (2) step();
        chk("t4_we_pulses", 32'(we_cnt - we0), 32'd1);
        chk("t4_acks", 32'(n_ack - a0), 32'd1);
        chk("t4_mem", 32'(mem[10'h030]), 32'h77);

        // Video strobe while a CPU access is in flight
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h030; k = cyc;
        cq.push_back('{k + 1, 1'b1, 8'h77});
        step(); ce_vid = 1'b1; vid_addr = 10'h155;
        @(negedge clk);
        chk("t5_blocked_addr", 32'(ram_addr), 32'h0);
        step(); ce_vid = 1'b0; vid_addr = 10'h3FF;
        vq.push_back('{k + 4, 8'hA5});
        @(negedge clk);
        chk("t5_latched_addr", 32'(ram_addr), 32'h155);
        chk("t5_ready", 32'(cpu_ready), 32'h1);
        step(); cpu_req = 1'b0;
        repeat (4) step();

        // Request dropped right after issue still completes
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h020; k = cyc;
        cq.push_back('{k + 1, 1'b1, 8'h3C});
        step(); cpu_req = 1'b0;
        repeat (3) step();

        // Reset during a CPU write issue cycle
        we0 = we_cnt; a0 = n_ack;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h040; cpu_wdata = 8'hEE;
        reset = 1'b1;
        @(negedge clk);
        chk("t7_ram_we", 32'(ram_we), 32'h0);
        chk("t7_ram_addr", 32'(ram_addr), 32'h0);
        step(); reset = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        chk("t7_vid_data", 32'(vid_data), 32'h00);
        chk("t7_cpu_rdata", 32'(cpu_rdata), 32'h00);
        chk("t7_cpu_ack", 32'(cpu_ack), 32'h0);
        chk("t7_cpu_ready", 32'(cpu_ready), 32'h1);
        repeat (3) step();
        chk("t7_mem", 32'(mem[10'h040]), 32'h11);
        chk("t7_we_pulses", 32'(we_cnt - we0), 32'd0);
        chk("t7_acks", 32'(n_ack - a0), 32'd0);

        chk("vid_queue_left", 32'(vq.size()), 32'd0);
        chk("cpu_queue_left", 32'(cq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
